motor_cmd_sequencer: RTL and testbench
======================================

MOTOR_CMD_SEQUENCER -- requirements
Module: motor_cmd_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 2097152, clk cycles per duration tick.
REQ-002 SHALL have parameter GAP_CYCLES, default 1024, coast cycles between motion end and done.
REQ-003 SHALL have parameter RAMP_DIV, default 4096, clk cycles per power ramp step (used only when ramp is compiled in).
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 cmd_valid  input  1  command triple cmd1..cmd3 is valid.
REQ-007 cmd_ready  output  1  block can accept a command.
REQ-008 cmd1  input  8  mode; bits[1:0]: 00 stop, 01 forward, 10 reverse, 11 spin; bits[7:2] ignored.
REQ-009 cmd2  input  8  target power; bits[6:0] used, bit 7 ignored.
REQ-010 cmd3  input  8  duration in ticks.
REQ-011 abort  input  1  terminate current motion.
REQ-012 power  output  7  PWM duty to the pwm stage.
REQ-013 dir  output  2  {left_rev, right_rev}: forward 00, reverse 11, spin 01, stop 00.
REQ-014 motor_en  output  1  H-bridge enable.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle completion pulse.

Function
REQ-017 SHALL implement states IDLE, RUN, COAST; cmd_ready = (state == IDLE).
REQ-018 SHALL accept a command on a rising edge where cmd_valid and cmd_ready are both high, latching cmd1[1:0], cmd2[6:0], and cmd3.
REQ-019 On acceptance with mode != 00 and cmd3 != 0, SHALL enter RUN after that same edge, with motor_en=1, dir per REQ-013, and tick and duration counters cleared.
REQ-020 On acceptance with mode == 00 or cmd3 == 0, SHALL enter COAST directly, with motor_en=0 and power=0.
REQ-021 In RUN, SHALL increment the tick counter each cycle, wrapping at TICK_DIV-1 and incrementing the duration counter on each wrap.
REQ-022 SHALL leave RUN for COAST when the duration counter reaches cmd3, so RUN lasts exactly cmd3*TICK_DIV cycles.
REQ-023 On entering COAST, SHALL drive motor_en=0 and power=0; dir SHALL hold its value.
REQ-024 SHALL remain in COAST for GAP_CYCLES cycles, then return to IDLE, pulsing done high for exactly the first IDLE cycle.
REQ-025 abort high in RUN SHALL force COAST on the next edge; abort in IDLE or COAST SHALL be ignored.
REQ-026 abort coinciding with the final tick SHALL produce a single COAST entry and a single done pulse.
REQ-027 cmd_valid while busy SHALL be ignored; inputs are not latched.
REQ-028 A new command MAY be accepted in the same cycle done is high.
REQ-029 Counters SHALL be wide enough for TICK_DIV, 8-bit duration, and GAP_CYCLES with no overflow.

Reset
REQ-030 reset SHALL asynchronously force state=IDLE, all counters=0, power=0, dir=00, motor_en=0, done=0, busy=0, cmd_ready=1.
REQ-031 Reset asserted mid-RUN SHALL drop motor_en in the same cycle, without waiting for a clock edge, and SHALL NOT produce a done pulse.

Configuration
REQ-032 Macro MOTOR_RAMP_EN defined: in RUN, power SHALL start at 0 and increase by 1 every RAMP_DIV cycles until equal to cmd2[6:0], then hold; duration timing is unaffected.
REQ-033 Macro MOTOR_RAMP_EN undefined: power SHALL equal cmd2[6:0] from the first RUN cycle; RAMP_DIV SHALL be unused.

Verification (bench parameters TICK_DIV=4, GAP_CYCLES=2, RAMP_DIV=2)
REQ-034 cmd1=01, cmd2=0x40, cmd3=3 -> motor_en high 12 cycles, power 64, dir 00; then 2 COAST cycles; done high 1 cycle.
REQ-035 cmd1=10, cmd3=0 -> no motor_en pulse; COAST 2 cycles; done 1 cycle; dir holds its prior value.
REQ-036 cmd1=11, cmd3=5, abort at RUN cycle 6 -> motor_en falls at edge 7; exactly one done pulse.
REQ-037 Second cmd_valid mid-RUN -> ignored; original timing kept; back-to-back command accepted in the done cycle.
REQ-038 Reset asserted at RUN cycle 3 -> outputs at reset values immediately; no done pulse; cmd_ready=1.
REQ-039 With MOTOR_RAMP_EN, cmd2=3, cmd3=4 -> power sequence 0,0,1,1,2,2,3... holding at 3; RUN still 16 cycles.

Source files
------------

// File: rtl/motor_cmd_sequencer.sv
// Motor command sequencer: accepts a mode/power/duration triple, runs the H-bridge for the
// commanded number of ticks, coasts for a fixed gap, then pulses done. Optional ramp: MOTOR_RAMP_EN.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for a command; cmd_ready high
// S_RUN   | bridge enabled, power applied, tick/duration counters running
// S_COAST | bridge disabled, power 0, gap countdown before done
module motor_cmd_sequencer #(
    parameter int TICK_DIV   = 2097152,
    parameter int GAP_CYCLES = 1024,
    parameter int RAMP_DIV   = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [7:0] cmd1_i,
    input  logic [7:0] cmd2_i,
    input  logic [7:0] cmd3_i,
    input  logic       abort_i,
    output logic [6:0] power_o,
    output logic [1:0] dir_o,
    output logic       motor_en_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_COAST = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [7:0]        dur_q, dur_d;
    logic [7:0]        dur_tgt_q, dur_tgt_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [6:0]        pwr_tgt_q, pwr_tgt_d;
    logic [1:0]        dir_q, dir_d;
    logic              done_q, done_d;

    logic tick_last;
    logic run_end;
    logic unused_cmd_bits;

    assign unused_cmd_bits = ^{cmd1_i[7:2], cmd2_i[7]};

    // {left_rev, right_rev}
    function automatic logic [1:0] dir_decode(input logic [1:0] mode);
        case (mode)
            2'b10:   dir_decode = 2'b11;
            2'b11:   dir_decode = 2'b01;
            default: dir_decode = 2'b00;
        endcase
    endfunction

    assign tick_last = (tick_q == TICK_LAST);
    // dur_tgt_q is never 0 while in RUN, so the subtraction cannot wrap there
    assign run_end   = tick_last && (dur_q == (dur_tgt_q - 8'd1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            tick_q    <= '0;
            dur_q     <= '0;
            dur_tgt_q <= '0;
            gap_q     <= '0;
            pwr_tgt_q <= '0;
            dir_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            dur_q     <= dur_d;
            dur_tgt_q <= dur_tgt_d;
            gap_q     <= gap_d;
            pwr_tgt_q <= pwr_tgt_d;
            dir_q     <= dir_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        dur_d     = dur_q;
        dur_tgt_d = dur_tgt_q;
        gap_d     = gap_q;
        pwr_tgt_d = pwr_tgt_q;
        dir_d     = dir_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    pwr_tgt_d = cmd2_i[6:0];
                    dur_tgt_d = cmd3_i;
                    tick_d    = '0;
                    dur_d     = '0;
                    if ((cmd1_i[1:0] != 2'b00) && (cmd3_i != 8'd0)) begin
                        state_d = S_RUN;
                        dir_d   = dir_decode(cmd1_i[1:0]);
                    end else begin
                        // stop / zero-length commands keep the previous direction
                        state_d = S_COAST;
                        gap_d   = GAP_LAST;
                    end
                end
            end
            S_RUN: begin
                if (abort_i || run_end) begin
                    state_d = S_COAST;
                    gap_d   = GAP_LAST;
                end else if (tick_last) begin
                    tick_d = '0;
                    dur_d  = dur_q + 8'd1;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            S_COAST: begin
                if (gap_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef MOTOR_RAMP_EN
    localparam int RAMP_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_DIV - 1);

    logic [6:0]        power_q, power_d;
    logic [RAMP_W-1:0] ramp_q, ramp_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            power_q <= '0;
            ramp_q  <= '0;
        end else begin
            power_q <= power_d;
            ramp_q  <= ramp_d;
        end
    end

    // Ramp restarts from zero on every RUN entry and saturates at the target.
    always_comb begin
        power_d = '0;
        ramp_d  = '0;
        if ((state_q == S_RUN) && (state_d == S_RUN)) begin
            power_d = power_q;
            if (ramp_q == RAMP_LAST) begin
                if (power_q < pwr_tgt_q) begin
                    power_d = power_q + 7'd1;
                end
            end else begin
                ramp_d = ramp_q + 1'b1;
            end
        end
    end

    assign power_o = (state_q == S_RUN) ? power_q : 7'd0;
`else
    localparam int unused_ramp_div = RAMP_DIV;

    assign power_o = (state_q == S_RUN) ? pwr_tgt_q : 7'd0;
`endif

    assign cmd_ready_o = (state_q == S_IDLE);
    assign busy_o      = (state_q != S_IDLE);
    assign motor_en_o  = (state_q == S_RUN);
    assign dir_o       = dir_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// Scoreboard bench for motor_cmd_sequencer: stimulus pushes expected run/coast/power/dir per
// command; a negedge monitor measures each transaction and compares when done pulses.
module tb_motor_cmd_sequencer;

    localparam int TICK_DIV   = 4;
    localparam int GAP_CYCLES = 2;
    localparam int RAMP_DIV   = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid_i = 1'b0;
    logic       cmd_ready_o;
    logic [7:0] cmd1_i = 8'h00;
    logic [7:0] cmd2_i = 8'h00;
    logic [7:0] cmd3_i = 8'h00;
    logic       abort_i = 1'b0;
    logic [6:0] power_o;
    logic [1:0] dir_o;
    logic       motor_en_o;
    logic       busy_o;
    logic       done_o;

    motor_cmd_sequencer #(
        .TICK_DIV  (TICK_DIV),
        .GAP_CYCLES(GAP_CYCLES),
        .RAMP_DIV  (RAMP_DIV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o),
        .cmd1_i     (cmd1_i),
        .cmd2_i     (cmd2_i),
        .cmd3_i     (cmd3_i),
        .abort_i    (abort_i),
        .power_o    (power_o),
        .dir_o      (dir_o),
        .motor_en_o (motor_en_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         run;
        int         coast;
        logic [6:0] pwr;
        logic [1:0] dir;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   done_seen = 0;
    int   done_exp = 0;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    bit   in_txn = 0;
    bit   prev_done = 0;
    int   run_cnt = 0;
    int   coast_cnt = 0;
    exp_t e;
    int   ep;

    always @(negedge clk) begin
        if (reset) begin
            in_txn    = 0;
            prev_done = 0;
        end else begin
            if (prev_done) check("done_width", done_o, 0);
            prev_done = done_o;
            if (busy_o && !in_txn) begin
                in_txn    = 1;
                run_cnt   = 0;
                coast_cnt = 0;
            end
            if (in_txn && busy_o) begin
                if (motor_en_o) begin
                    if (exp_q.size() > 0) begin
`ifdef MOTOR_RAMP_EN
                        ep = run_cnt / RAMP_DIV;
                        if (ep > int'(exp_q[0].pwr)) ep = int'(exp_q[0].pwr);
`else
                        ep = int'(exp_q[0].pwr);
`endif
                        check("run_power", power_o, ep);
                    end
                    run_cnt++;
                end else begin
                    check("coast_power", power_o, 0);
                    coast_cnt++;
                end
            end
            if (done_o) begin
                done_seen++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got a done pulse, expected none (t=%0t)", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("run_cycles", run_cnt, e.run);
                    check("coast_cycles", coast_cnt, e.coast);
                    check("dir_at_done", dir_o, e.dir);
                    check("busy_at_done", busy_o, 0);
                    check("ready_at_done", cmd_ready_o, 1);
                end
                in_txn = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [7:0] c1, input logic [7:0] c2, input logic [7:0] c3,
                        input bit push, input int run, input logic [1:0] d);
        int t = 0;
        @(negedge clk);
        while (!cmd_ready_o && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready_o) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: cmd_ready stayed 0, expected 1");
        end
        if (push) begin
            exp_q.push_back('{run, GAP_CYCLES, c2[6:0], d});
            done_exp++;
        end
        cmd_valid_i = 1'b1;
        cmd1_i = c1;
        cmd2_i = c2;
        cmd3_i = c3;
        @(posedge clk);
        #1;
        cmd_valid_i = 1'b0;
        cmd1_i = 8'hFF;
        cmd2_i = 8'hFF;
        cmd3_i = 8'hFF;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_power"}, power_o, 0);
        check({tag, "_dir"}, dir_o, 0);
        check({tag, "_motor_en"}, motor_en_o, 0);
        check({tag, "_done"}, done_o, 0);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_ready"}, cmd_ready_o, 1);
    endtask

    initial begin
        int t;
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b0;

        // forward 3 ticks; abort during COAST must be ignored
        send(8'h01, 8'h40, 8'h03, 1, 12, 2'b00);
        repeat (12) begin @(posedge clk); #1; end
        abort_i = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        abort_i = 1'b0;

        // spin 5 ticks, abort in the 6th RUN cycle
        send(8'h03, 8'h25, 8'h05, 1, 6, 2'b01);
        repeat (5) begin @(posedge clk); #1; end
        abort_i = 1'b1;
        @(posedge clk); #1;
        abort_i = 1'b0;

        // reverse with zero duration, then stop mode with junk upper bits: dir holds 01
        send(8'h02, 8'h55, 8'h00, 1, 0, 2'b01);
        send(8'hFC, 8'h7F, 8'h04, 1, 0, 2'b01);

        // reverse 1 tick, abort coinciding with the final tick
        send(8'h02, 8'h11, 8'h01, 1, 4, 2'b11);
        repeat (3) begin @(posedge clk); #1; end
        abort_i = 1'b1;
        @(posedge clk); #1;
        abort_i = 1'b0;

        // forward with junk mode bits; a second command mid-RUN is ignored
        send(8'h05, 8'hC8, 8'h02, 1, 8, 2'b00);
        repeat (3) begin @(posedge clk); #1; end
        cmd_valid_i = 1'b1;
        cmd1_i = 8'h03;
        cmd2_i = 8'h7F;
        cmd3_i = 8'h01;
        repeat (2) begin @(posedge clk); #1; end
        cmd_valid_i = 1'b0;

        // back-to-back: present the next command in the done cycle
        t = 0;
        @(negedge clk);
        while (!done_o && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("b2b_done_seen", done_o, 1);
        check("b2b_ready", cmd_ready_o, 1);
        exp_q.push_back('{4, GAP_CYCLES, 7'h01, 2'b00});
        done_exp++;
        cmd_valid_i = 1'b1;
        cmd1_i = 8'h01;
        cmd2_i = 8'h01;
        cmd3_i = 8'h01;
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        check("b2b_busy", busy_o, 1);
        check("b2b_motor_en", motor_en_o, 1);

        // abort while idle is ignored
        t = 0;
        @(negedge clk);
        while (!(cmd_ready_o && !done_o) && t < 100) begin
            @(negedge clk);
            t++;
        end
        abort_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_abort_busy", busy_o, 0);
        end
        abort_i = 1'b0;

        // reset during RUN cycle 3: outputs drop immediately, no done
        send(8'h03, 8'h20, 8'h05, 0, 0, 2'b01);
        repeat (2) begin @(posedge clk); #1; end
        check("pre_reset_motor_en", motor_en_o, 1);
        check("pre_reset_dir", dir_o, 1);
        reset = 1'b1;
        #1;
        check_reset_outputs("mid_run_reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // recovery run; under ramp this is the 0,0,1,1,2,2,3... sequence
        send(8'h01, 8'h03, 8'h04, 1, 16, 2'b00);

        t = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || busy_o) && t < 500) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        check("pending_expectations", exp_q.size(), 0);
        check("done_count", done_seen, done_exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
